fetch_pc_sequencer: RTL and testbench

- Write-side companion to the 32-bit PC register. Owns the program counter and produces every next-PC value.
- Issues instruction-memory fetches with a req/ack handshake and delivers fetched instructions to decode with valid/stall flow control.
- Absorbs branch/jump redirects arriving at any point in the fetch cycle.
- Sits between the branch-resolution logic, instruction memory and the decode stage.

---
 rtl/fetch_pc_sequencer.sv | 104 ++++++++++
 tb/tb_fetch_pc_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_sequencer.sv
// Program counter owner and instruction fetch sequencer: issues req/ack fetches
// to instruction memory, delivers words to decode, and absorbs branch redirects.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_out
);

  // Handshakes: imem_req stays high with imem_addr frozen until imem_ack is seen
  // on a rising edge; inst_valid holds inst_out/inst_pc until a cycle with stall=0.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        pending_v;
  logic [31:0] pending_target;
  logic [31:0] redirect_pc;
  logic        unused_target_bits;

  assign redirect_pc        = {redirect_target[31:2], 2'b00};
  assign unused_target_bits = ^redirect_target[1:0];
  assign imem_addr          = pc;
  assign pc_out             = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      pending_v      <= 1'b0;
      pending_target <= 32'h0;
      imem_req       <= 1'b0;
      inst_valid     <= 1'b0;
      inst_out       <= 32'h0;
      inst_pc        <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (imem_ack) begin
            // A redirect arriving with the ack beats an older pending one.
            if (redirect_valid) begin
              pc        <= redirect_pc;
              pending_v <= 1'b0;
            end else if (pending_v) begin
              pc        <= pending_target;
              pending_v <= 1'b0;
            end else begin
              inst_out   <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + PC_STEP;
              imem_req   <= 1'b0;
              state      <= DELIVER;
            end
          end else if (redirect_valid) begin
            // Address must stay stable mid-request, so park the target.
            pending_v      <= 1'b1;
            pending_target <= redirect_pc;
          end
        end

        DELIVER: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            pc         <= redirect_pc;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end else if (!stall) begin
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: the driver pushes expected fetch
// addresses and delivered {pc, inst} pairs; a negedge monitor pops and compares.
module tb_fetch_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_out;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  int checks   = 0;
  int failures = 0;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  fetch_pc_sequencer #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk             (clk),
    .reset           (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .pc_out          (pc_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1ns after the falling edge
  task automatic drive(input logic ack, input logic [31:0] rd, input logic rv,
                       input logic [31:0] rt, input logic st);
    imem_ack        = ack;
    imem_rdata      = rd;
    redirect_valid  = rv;
    redirect_target = rt;
    stall           = st;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      n++;
    end
    check("req_timeout", {63'b0, imem_req}, 64'd1);
  endtask

  // Monitor / scoreboard
  logic        prev_req;
  logic [31:0] prev_addr;
  logic        prev_valid;
  logic [31:0] prev_out;
  logic [31:0] prev_pc;

  always @(negedge clk) begin
    if (rst) begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (imem_req && (!prev_req || imem_ack)) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_unexpected: got addr %h expected no request", imem_addr);
        end else begin
          check("fetch_addr", {32'h0, imem_addr}, {32'h0, exp_addr_q.pop_front()});
        end
      end else if (imem_req && prev_req) begin
        check("addr_stable", {32'h0, imem_addr}, {32'h0, prev_addr});
      end

      if (inst_valid && !prev_valid) begin
        if (exp_inst_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL inst_unexpected: got pc %h inst %h expected none", inst_pc, inst_out);
        end else begin
          check("deliver_pc_inst", {inst_pc, inst_out}, exp_inst_q.pop_front());
        end
      end else if (inst_valid && prev_valid) begin
        check("inst_hold", {inst_pc, inst_out}, {prev_pc, prev_out});
      end

      prev_req   = imem_req;
      prev_addr  = imem_addr;
      prev_valid = inst_valid;
      prev_out   = inst_out;
      prev_pc    = inst_pc;
    end
  end

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; redirect_valid = 1'b0;
    redirect_target = 32'h0; stall = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("reset_pc",         {32'h0, pc_out},  {32'h0, RESET_PC});
    check("reset_req",        {63'b0, imem_req}, 64'd0);
    check("reset_inst_valid", {63'b0, inst_valid}, 64'd0);
    check("reset_inst_out",   {32'h0, inst_out}, 64'd0);
    check("reset_inst_pc",    {32'h0, inst_pc},  64'd0);

    // Sequential fetch with zero-wait memory, then a 5-cycle stall on inst_pc=0x4
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_inst_q.push_back({32'h0, 32'h1111_0001});
    exp_inst_q.push_back({32'h4, 32'h1111_0002});
    rst = 1'b0;
    wait_req();
    drive(1'b1, 32'h1111_0001, 1'b0, 32'h0, 1'b0);
    wait_req();
    drive(1'b1, 32'h1111_0002, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check("stall_req_low", {63'b0, imem_req}, 64'd0);
    end
    check("stall_inst_pc", {32'h0, inst_pc}, 64'h4);
    exp_addr_q.push_back(32'h8);
    exp_inst_q.push_back({32'h8, 32'h1111_0003});
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h1111_0003, 1'b0, 32'h0, 1'b0);

    // Redirect to 0x203 two cycles before the ack of the 0x10 fetch
    exp_addr_q.push_back(32'hC);
    exp_addr_q.push_back(32'h10);
    exp_addr_q.push_back(32'h200);
    exp_inst_q.push_back({32'hC, 32'h1111_0004});
    exp_inst_q.push_back({32'h200, 32'hAAAA_0200});
    wait_req();
    drive(1'b1, 32'h1111_0004, 1'b0, 32'h0, 1'b0);
    wait_req();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h203, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'hDEAD_0010, 1'b0, 32'h0, 1'b0);
    check("drop_no_valid", {63'b0, inst_valid}, 64'd0);
    drive(1'b1, 32'hAAAA_0200, 1'b0, 32'h0, 1'b0);

    // Two pending redirects, then a same-cycle redirect with the ack wins
    exp_addr_q.push_back(32'h204);
    exp_addr_q.push_back(32'h500);
    exp_inst_q.push_back({32'h500, 32'hBBBB_0500});
    wait_req();
    drive(1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
    drive(1'b1, 32'hDEAD_0204, 1'b1, 32'h500, 1'b0);
    drive(1'b1, 32'hBBBB_0500, 1'b0, 32'h0, 1'b0);

    // Redirect beats stall in DELIVER
    exp_addr_q.push_back(32'h80);
    exp_inst_q.push_back({32'h80, 32'hCCCC_0080});
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    check("flush_valid", {63'b0, inst_valid}, 64'd0);
    check("flush_pc",    {32'h0, pc_out},     64'h80);
    drive(1'b1, 32'hCCCC_0080, 1'b0, 32'h0, 1'b0);

    // Wrap from 0xFFFF_FFFC (target low bits masked), then reset mid-fetch with a pending redirect
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_inst_q.push_back({32'hFFFF_FFFC, 32'hDDDD_FFFC});
    exp_inst_q.push_back({32'h0, 32'hEEEE_0000});
    drive(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 32'hDDDD_FFFC, 1'b0, 32'h0, 1'b0);
    check("wrap_pc", {32'h0, pc_out}, 64'h0);
    wait_req();
    drive(1'b1, 32'hEEEE_0000, 1'b0, 32'h0, 1'b0);
    wait_req();
    drive(1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_req", {63'b0, imem_req}, 64'd0);
    check("async_reset_pc",  {32'h0, pc_out},   {32'h0, RESET_PC});
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp_addr_q.push_back(RESET_PC);
    exp_inst_q.push_back({RESET_PC, 32'h1234_5678});
    rst = 1'b0;
    wait_req();
    drive(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    check("inst_q_empty", 64'(exp_inst_q.size()), 64'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
